// File: rtl/conv_pkg.sv
// Shared state type and default geometry for the 3-tap image streaming path.
package conv_pkg;

    localparam int unsigned DEF_IMG_SIZE   = 5;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_KERNEL     = 3;
    localparam int unsigned DEF_OUT_SIZE   = DEF_IMG_SIZE - DEF_KERNEL + 1;
    localparam int unsigned DEF_N_PIX      = DEF_IMG_SIZE * DEF_IMG_SIZE;
    localparam int unsigned DEF_N_ISSUE    = DEF_OUT_SIZE * DEF_OUT_SIZE * DEF_KERNEL;
    localparam int unsigned DEF_PIX_AW     = $clog2(DEF_N_PIX);
    localparam int unsigned DEF_ISSUE_W    = $clog2(DEF_N_ISSUE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } conv_state_e;

endpackage

// File: rtl/conv_issue_counter.sv
// Counts issued read strobes and the tap position within a window row;
// flags the final tap of a row and the final issue of a frame.
module conv_issue_counter #(
    parameter int unsigned N_ISSUE = 27,
    parameter int unsigned KERNEL  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic advance_i,
    output logic is_tap_last_o,
    output logic is_final_o
);

    localparam int unsigned CW = $clog2(N_ISSUE + 1);
    localparam int unsigned KW = (KERNEL > 1) ? $clog2(KERNEL) : 1;
    localparam logic [CW-1:0] LAST_ISSUE = CW'(N_ISSUE - 1);
    localparam logic [KW-1:0] LAST_TAP   = KW'(KERNEL - 1);

    logic [CW-1:0] issue_cnt_q;
    logic [KW-1:0] tap_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            issue_cnt_q <= '0;
            tap_q       <= '0;
        end else if (advance_i) begin
            issue_cnt_q <= issue_cnt_q + CW'(1);
            tap_q       <= (tap_q == LAST_TAP) ? '0 : tap_q + KW'(1);
        end
    end

    assign is_tap_last_o = (tap_q == LAST_TAP);
    assign is_final_o    = (issue_cnt_q == LAST_ISSUE);

endmodule

// File: rtl/conv_sequencer.sv
// Frame controller: preloads an image into the buffer from a valid/ready
// stream, then issues the window read strobes under MAC backpressure.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_SIZE   = DEF_IMG_SIZE,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned KERNEL     = DEF_KERNEL
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic                                  in_valid,
    input  logic [DATA_WIDTH-1:0]                 in_pixel,
    output logic                                  in_ready,
    input  logic                                  mac_ready,
    output logic                                  buf_clear,
    output logic                                  buf_preload_en,
    output logic [$clog2(IMG_SIZE*IMG_SIZE)-1:0]  buf_preload_addr,
    output logic [DATA_WIDTH-1:0]                 buf_preload_pixel,
    output logic                                  buf_preload_done,
    output logic                                  buf_enable,
    output logic                                  buf_next_pixel,
    output logic                                  tap_last,
    output logic                                  frame_last,
    output logic                                  busy,
    output logic                                  done
);

    localparam int unsigned OUT_SIZE = IMG_SIZE - KERNEL + 1;
    localparam int unsigned N_PIX    = IMG_SIZE * IMG_SIZE;
    localparam int unsigned N_ISSUE  = OUT_SIZE * OUT_SIZE * KERNEL;
    localparam int unsigned PIX_AW   = $clog2(N_PIX);
    localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(N_PIX - 1);

    conv_state_e       state_q;
    logic [PIX_AW-1:0] load_cnt_q;
    logic              preload_done_q;
    logic              tap_last_q;
    logic              frame_last_q;

    logic abort_eff;
    logic wr;
    logic strobe;
    logic issue_clear;
    logic is_tap_last;
    logic is_final;

    // abort outranks any same-cycle write or strobe, so gate both here
    assign abort_eff   = abort && (state_q != ST_IDLE);
    assign in_ready    = (state_q == ST_LOAD) && !abort;
    assign wr          = in_ready && in_valid;
    assign strobe      = (state_q == ST_STREAM) && mac_ready && !abort_eff;
    assign issue_clear = (state_q == ST_CLEAR) || abort_eff;

    conv_issue_counter #(
        .N_ISSUE (N_ISSUE),
        .KERNEL  (KERNEL)
    ) u_issue (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (issue_clear),
        .advance_i     (strobe),
        .is_tap_last_o (is_tap_last),
        .is_final_o    (is_final)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            load_cnt_q     <= '0;
            preload_done_q <= 1'b0;
            tap_last_q     <= 1'b0;
            frame_last_q   <= 1'b0;
        end else begin
            tap_last_q   <= strobe && is_tap_last;
            frame_last_q <= strobe && is_final;
            if (abort_eff) begin
                state_q        <= ST_IDLE;
                load_cnt_q     <= '0;
                preload_done_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q        <= ST_CLEAR;
                            preload_done_q <= 1'b0;
                        end
                    end
                    ST_CLEAR: begin
                        load_cnt_q <= '0;
                        state_q    <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (wr) begin
                            load_cnt_q <= load_cnt_q + PIX_AW'(1);
                            if (load_cnt_q == LAST_PIX) begin
                                state_q        <= ST_STREAM;
                                preload_done_q <= 1'b1;
                            end
                        end
                    end
                    ST_STREAM: begin
                        if (strobe && is_final)
                            state_q <= ST_DRAIN;
                    end
                    ST_DRAIN: state_q <= ST_DONE;
                    ST_DONE:  state_q <= ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign buf_clear         = (state_q == ST_CLEAR) || abort_eff;
    assign buf_preload_en    = wr;
    assign buf_preload_addr  = wr ? load_cnt_q : '0;
    assign buf_preload_pixel = wr ? in_pixel : '0;
    assign buf_preload_done  = preload_done_q;
    assign buf_enable        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign buf_next_pixel    = strobe;
    assign tap_last          = tap_last_q;
    assign frame_last        = frame_last_q;
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);

endmodule
